aes_bus_regs: RTL
=================

Name: aes_bus_regs

Overview:
- Sits on the die directly behind the input/output pad ring.
- Consumes the byte-wide host bus: valid, wen, addr[7:0], wdata[7:0], rdata[7:0].
- Assembles 128-bit key and plaintext registers, launches the AES core with a one-cycle start pulse, and captures the 128-bit result.
- Exposes control, status and result back to the host over the same byte bus.

Parameters:
- TIMEOUT, 64, max cycles to wait for core_done after start before aborting (must be >= 2).
- ID_VALUE, 8'hA5, constant returned at address 0x32.

Ports:
- clk  in  1  core clock, same net as the bus clock.
- resetn  in  1  asynchronous, active-low reset.
- valid  in  1  bus transaction qualifier, one cycle per access.
- wen  in  1  1 = write, 0 = read; sampled only when valid=1.
- addr  in  8  byte address.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- key  out  128  key register to the core.
- text_in  out  128  plaintext register to the core.
- start  out  1  one-cycle pulse launching the core.
- core_done  in  1  one-cycle pulse from the core: text_out is valid.
- text_out  in  128  core result.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on resetn; assertion clears all registers immediately.
  - Cleared to 0: key, text_in, result, rdata, start, busy, done, err, timeout counter. FSM goes to IDLE.
  - Reset while BUSY or START abandons the operation; a later core_done is ignored, because the FSM is IDLE.
- Address map (byte i of a 128-bit register at offset i maps to bits [127-8i -: 8], so byte 0 is the MSB):
  - 0x00-0x0F: key, R/W.
  - 0x10-0x1F: text_in, R/W.
  - 0x20-0x2F: result, RO.
  - 0x30: CTRL, write-only, reads 0.
    - bit0 START.
    - bit1 CLR_DONE.
    - bit2 CLR_ERR.
  - 0x31: STATUS, RO. bit0 busy, bit1 done, bit2 err, bits[7:3]=0.
  - 0x32: ID, returns ID_VALUE.
  - All other addresses: reads 0, writes ignored.
- Writes (valid=1, wen=1) take effect at the same clock edge. Writes to RO addresses are silently ignored.
- Reads (valid=1, wen=0) at edge N load rdata at edge N; the value is visible in cycle N+1 (one-cycle latency). rdata holds its value until the next read.
- FSM states:
  - IDLE: busy=0. A CTRL write with bit0=1 goes to START.
  - START: start=1 for exactly one cycle, busy=1, counter cleared. Always goes to BUSY next.
  - BUSY: busy=1, counter increments each cycle.
    - core_done=1: result<=text_out, done<=1, go to IDLE.
    - counter reaches TIMEOUT-1 without core_done: err<=1, go to IDLE. result and done are unchanged.
- Boundary conditions:
  - START write while busy (START or BUSY state): ignored, err<=1.
  - key or text_in write while busy: ignored, err<=1. These registers stay stable for the whole operation.
  - core_done in IDLE or START: ignored.
  - core_done on the same cycle as the timeout: core_done wins; no err.
  - CTRL write with START and CLR_DONE together, from IDLE: done<=0 and FSM goes to START.
  - CLR_DONE on the same cycle as a core_done capture: the capture wins, done=1.
  - CLR_ERR on the same cycle as a new error event: the set wins.
  - A read of STATUS or result on the same cycle as an update returns the pre-update value.
- done and err are sticky until cleared by CTRL or by reset.

Decomposition:
- Package aes_bus_pkg holds:
  - address constants: KEY_BASE, TXT_BASE, RES_BASE, CTRL_ADDR, STAT_ADDR, ID_ADDR;
  - CTRL and STATUS bit indices;
  - the FSM state enum (IDLE, START, BUSY).
- Sub-module aes_byte_bank: a 16x8 bank with a byte write-enable and 4-bit index, exposing a 128-bit flat output. It is instantiated for key and text_in.
- Result capture, read mux, FSM and timeout counter stay in the top module.

Test Plan:
- Reset, then read 0x31 and 0x32 -> rdata=8'h00 then 8'hA5 one cycle after each read. start=0 throughout.
- Write bytes 0x00..0x0F with 00,01,..,0F -> key=128'h000102030405060708090a0b0c0d0e0f. Read back 0x05 -> 8'h05.
- Write CTRL=0x01 -> start high exactly 1 cycle, STATUS=0x01. Core model pulses core_done with text_out=128'h69c4e0d86a7b0430d8cdb78070b4c55a after 10 cycles -> STATUS=0x02, address 0x20 reads 8'h69, address 0x2F reads 8'h5a.
- While BUSY, write 0x00=FF and CTRL=0x01 -> key unchanged, no second start pulse, STATUS=0x05. After done: STATUS=0x06. Write CTRL=0x06 -> STATUS=0x00.
- Start with no core_done -> after TIMEOUT cycles STATUS=0x04, FSM IDLE, result unchanged.
- Assert resetn=0 mid-BUSY, then core_done pulse after release -> all registers 0, STATUS=0x00, result stays 0.

Source files
------------

// File: rtl/aes_bus_regs_pkg.sv
// Shared constants for the AES host-bus register block: address map,
// CTRL/STATUS bit positions, FSM state encoding and a byte-pick helper.
package aes_bus_pkg;

  localparam logic [7:0] KEY_BASE  = 8'h00;
  localparam logic [7:0] TXT_BASE  = 8'h10;
  localparam logic [7:0] RES_BASE  = 8'h20;
  localparam logic [7:0] CTRL_ADDR = 8'h30;
  localparam logic [7:0] STAT_ADDR = 8'h31;
  localparam logic [7:0] ID_ADDR   = 8'h32;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_CLR_ERR  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  // Byte i of a 128-bit word; byte 0 is the MSB, so its LSB sits at 8*(15-i).
  function automatic logic [7:0] byte_pick(input logic [127:0] v, input logic [3:0] i);
    logic [6:0] lsb;
    lsb = {~i, 3'b000};
    return v[lsb +: 8];
  endfunction

endpackage

// File: rtl/aes_bus_regs_if.sv
// Byte-wide host bus: one-cycle valid-qualified accesses, registered read data.
interface aes_bus_regs_if;
  logic       valid;
  logic       wen;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output valid, output wen, output addr, output wdata, input rdata);
  modport slave  (input valid, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/aes_bus_regs_byte_bank.sv
// 16 x 8 register bank written one byte at a time, presented as a flat
// 128-bit word with byte 0 in the most significant position.
module aes_byte_bank (
  input  logic         clk,
  input  logic         resetn,
  input  logic         we,
  input  logic [3:0]   idx,
  input  logic [7:0]   wdata,
  output logic [127:0] q
);

  logic [7:0] byte_reg [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      // Each byte loads only when its index is addressed with the write enable.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          byte_reg[gi] <= 8'h00;
        end else if (we && (idx == 4'(gi))) begin
          byte_reg[gi] <= wdata;
        end
      end

      assign q[127 - 8*gi -: 8] = byte_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/aes_bus_regs.sv
// Host-bus register front end for an AES core: key/plaintext assembly,
// start/done handshake with timeout, result capture and byte read-back.
module aes_bus_regs
  import aes_bus_pkg::*;
#(
  parameter int         TIMEOUT  = 64,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic           clk,
  input  logic           resetn,
  aes_bus_regs_if.slave  bus,
  output logic [127:0]   key,
  output logic [127:0]   text_in,
  output logic           start,
  input  logic           core_done,
  input  logic [127:0]   text_out
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [127:0]    result_reg;
  logic [7:0]      rdata_reg, rdata_next;
  logic            done_reg, err_reg;

  logic wr_en, rd_en, busy;
  logic key_sel, txt_sel, ctrl_wr, start_req;
  logic capture, timed_out, err_set;
  logic [7:0] status;

  assign wr_en     = bus.valid & bus.wen;
  assign rd_en     = bus.valid & ~bus.wen;
  assign busy      = (state_reg != IDLE);
  assign key_sel   = wr_en && (bus.addr[7:4] == KEY_BASE[7:4]);
  assign txt_sel   = wr_en && (bus.addr[7:4] == TXT_BASE[7:4]);
  assign ctrl_wr   = wr_en && (bus.addr == CTRL_ADDR);
  assign start_req = ctrl_wr && bus.wdata[CTRL_START];

  // core_done is only honoured while waiting; it beats a coinciding timeout.
  assign capture   = (state_reg == BUSY) && core_done;
  assign timed_out = (state_reg == BUSY) && !core_done && (cnt_reg == CNT_LAST);

  // Any attempt to disturb an operation in flight is flagged, as is a timeout.
  assign err_set   = (busy && (start_req || key_sel || txt_sel)) || timed_out;

  assign status    = {5'b0, err_reg, done_reg, busy};
  assign start     = (state_reg == START);
  assign bus.rdata = rdata_reg;

  // Key and plaintext are frozen while the core is running.
  aes_byte_bank u_key_bank (
    .clk    (clk),
    .resetn (resetn),
    .we     (key_sel && !busy),
    .idx    (bus.addr[3:0]),
    .wdata  (bus.wdata),
    .q      (key)
  );

  aes_byte_bank u_txt_bank (
    .clk    (clk),
    .resetn (resetn),
    .we     (txt_sel && !busy),
    .idx    (bus.addr[3:0]),
    .wdata  (bus.wdata),
    .q      (text_in)
  );

  // Next state and timeout counter for the start/busy sequence.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_req) state_next = START;
      end
      START: begin
        cnt_next   = '0;
        state_next = BUSY;
      end
      BUSY: begin
        cnt_next = cnt_reg + 1'b1;
        if (capture || timed_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Sticky done/err flags; a set event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (capture)
        done_reg <= 1'b1;
      else if (ctrl_wr && bus.wdata[CTRL_CLR_DONE])
        done_reg <= 1'b0;

      if (err_set)
        err_reg <= 1'b1;
      else if (ctrl_wr && bus.wdata[CTRL_CLR_ERR])
        err_reg <= 1'b0;
    end
  end

  // Capture the core result when it signals completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_reg <= '0;
    end else if (capture) begin
      result_reg <= text_out;
    end
  end

  // Read mux over the address map; uses current register values, so a read
  // coinciding with an update sees the old value.
  always_comb begin
    rdata_next = 8'h00;
    case (bus.addr[7:4])
      KEY_BASE[7:4]: rdata_next = byte_pick(key, bus.addr[3:0]);
      TXT_BASE[7:4]: rdata_next = byte_pick(text_in, bus.addr[3:0]);
      RES_BASE[7:4]: rdata_next = byte_pick(result_reg, bus.addr[3:0]);
      CTRL_ADDR[7:4]: begin
        if (bus.addr == STAT_ADDR)    rdata_next = status;
        else if (bus.addr == ID_ADDR) rdata_next = ID_VALUE;
      end
      default: rdata_next = 8'h00;
    endcase
  end

  // Read data register; holds between reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_reg <= 8'h00;
    end else if (rd_en) begin
      rdata_reg <= rdata_next;
    end
  end

endmodule
